// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with parallel load, lock-up recovery to SEED,
// a shift counter and a once-per-period tick.
module lfsr_gen #(
  parameter int               WIDTH  = 12,
  parameter logic [WIDTH-1:0] TAPS   = 12'h829,
  parameter bit               XNOR   = 1'b1,
  parameter logic [WIDTH-1:0] SEED   = 12'h367,
  parameter int               PERIOD = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] count,
  output logic             max_tick,
  output logic             lockup_err
);

  // The state the feedback can never leave: all-ones for XNOR, all-zeros for XOR.
  localparam logic [WIDTH-1:0] LOCK = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  function automatic logic [WIDTH-1:0] next_state(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    if (XNOR) fb = ~fb;
    return {s[WIDTH-2:0], fb};
  endfunction

  // Priority load > shift > hold; pulses default low so they never stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out      <= SEED;
      count      <= '0;
      max_tick   <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      max_tick   <= 1'b0;
      lockup_err <= 1'b0;
      if (load) begin
        count <= '0;
        if (load_val == LOCK) begin
          q_out      <= SEED;
          lockup_err <= 1'b1;
        end else begin
          q_out <= load_val;
        end
      end else if (sh_en) begin
        if (q_out == LOCK) begin
          // Only reachable through a corrupted state; restart the sequence.
          q_out      <= SEED;
          count      <= '0;
          lockup_err <= 1'b1;
        end else if (count == LAST) begin
          q_out    <= next_state(q_out);
          count    <= '0;
          max_tick <= 1'b1;
        end else begin
          q_out <= next_state(q_out);
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: default 12-bit XNOR instance and a 4-bit XOR instance,
// checked against an independent bit-serial model through an expectation queue.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sh_en = 1'b0, load = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] q_out, count;
  logic        max_tick, lockup_err;

  logic       s_sh = 1'b0, s_ld = 1'b0;
  logic [3:0] s_lv = '0;
  logic [3:0] s_q, s_c;
  logic       s_t, s_e;

  lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .sh_en(sh_en), .load(load), .load_val(load_val),
    .q_out(q_out), .count(count), .max_tick(max_tick), .lockup_err(lockup_err)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .XNOR(1'b0), .SEED(4'h1), .PERIOD(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .sh_en(s_sh), .load(s_ld), .load_val(s_lv),
    .q_out(s_q), .count(s_c), .max_tick(s_t), .lockup_err(s_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] c;
    logic        t;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int          mw[2]    = '{12, 4};
  logic [31:0] mtaps[2] = '{32'h829, 32'hC};
  bit          mxn[2]   = '{1'b1, 1'b0};
  logic [31:0] mseed[2] = '{32'h367, 32'h1};
  int          mper[2]  = '{4095, 15};
  logic [31:0] mq[2], mc[2];
  logic        mt[2], me[2];

  function automatic logic [31:0] mnext(input int sel, input logic [31:0] s);
    logic fb;
    logic [31:0] mask;
    fb = 1'b0;
    for (int i = 0; i < mw[sel]; i++)
      if (mtaps[sel][i]) fb = fb ^ s[i];
    if (mxn[sel]) fb = ~fb;
    mask = (32'd1 << mw[sel]) - 32'd1;
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = mseed[k]; mc[k] = 0; mt[k] = 1'b0; me[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int sel, input bit sh, input bit ld, input logic [31:0] lv);
    logic [31:0] mask, lock;
    mask = (32'd1 << mw[sel]) - 32'd1;
    lock = mxn[sel] ? mask : 32'd0;
    mt[sel] = 1'b0;
    me[sel] = 1'b0;
    if (ld) begin
      mc[sel] = 0;
      if ((lv & mask) == lock) begin mq[sel] = mseed[sel]; me[sel] = 1'b1; end
      else mq[sel] = lv & mask;
    end else if (sh) begin
      if (mq[sel] == lock) begin
        mq[sel] = mseed[sel]; mc[sel] = 0; me[sel] = 1'b1;
      end else begin
        mq[sel] = mnext(sel, mq[sel]);
        if (mc[sel] == 32'(mper[sel] - 1)) begin mc[sel] = 0; mt[sel] = 1'b1; end
        else mc[sel] = mc[sel] + 1;
      end
    end
  endtask

  // Drive one cycle on the chosen instance (called at a falling edge), queue the
  // model's expectation, and return at the next falling edge.
  task automatic cyc(input int sel, input bit sh, input bit ld, input logic [31:0] lv);
    if (sel == 0) begin sh_en = sh; load = ld; load_val = lv[11:0]; end
    else begin s_sh = sh; s_ld = ld; s_lv = lv[3:0]; end
    model_step(sel, sh, ld, lv);
    exp_q.push_back('{q: mq[sel], c: mc[sel], t: mt[sel], e: me[sel]});
    @(posedge clk);
    @(negedge clk);
    sh_en = 1'b0; load = 1'b0; s_sh = 1'b0; s_ld = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({q_out, count, max_tick, lockup_err} !== {12'h367, 12'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got q=%h c=%h t=%b e=%b, want q=367 c=000 t=0 e=0",
               q_out, count, max_tick, lockup_err);
    end
    rst_n = 1'b1;
    cyc(0, 1'b1, 1'b0, 0);
    e = exp_q.pop_front();
    vectors++;
    if ({q_out, count, max_tick} !== {12'h6CF, 12'h001, 1'b0} ||
        {q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
      miscompares++;
      $display("FAIL first_shift: got q=%h c=%h t=%b, want q=6cf c=001 t=0", q_out, count, max_tick);
    end
  endtask

  task automatic test_full_period();
    exp_t e;
    bit seen[4096];
    int dups, ticks, t1, t2;
    dups = 0; ticks = 0; t1 = -1; t2 = -1;
    rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 8190; i++) begin
      cyc(0, 1'b1, 1'b0, 0);
      e = exp_q.pop_front();
      vectors++;
      if ({q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL period[%0d]: got q=%h c=%h t=%b e=%b, want q=%h c=%h t=%b e=%b", i,
                 q_out, count, max_tick, lockup_err, e.q[11:0], e.c[11:0], e.t, e.e);
      end
      if (i <= 4095) begin
        if (seen[q_out] || q_out == 12'hFFF) dups++;
        seen[q_out] = 1'b1;
      end
      if (max_tick === 1'b1) begin
        ticks++;
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
    end
    vectors++;
    if (dups != 0) begin
      miscompares++;
      $display("FAIL distinct_states: got %0d repeats/lock states, want 0", dups);
    end
    vectors++;
    if (ticks != 2 || t1 != 4095 || t2 != 8190) begin
      miscompares++;
      $display("FAIL tick_spacing: got %0d ticks at %0d,%0d, want 2 at 4095,8190", ticks, t1, t2);
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [11:0] lvs[3] = '{12'hFFF, 12'hABC, 12'h000};
    bit          shs[3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      cyc(0, shs[k], 1'b1, {20'd0, lvs[k]});
      e = exp_q.pop_front();
      vectors++;
      if ({q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL load[%h]: got q=%h c=%h t=%b e=%b, want q=%h c=%h t=%b e=%b", lvs[k],
                 q_out, count, max_tick, lockup_err, e.q[11:0], e.c[11:0], e.t, e.e);
      end
      cyc(0, 1'b0, 1'b0, 0);
      e = exp_q.pop_front();
      vectors++;
      if ({q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL load_hold[%h]: got q=%h c=%h e=%b, want q=%h c=%h e=%b", lvs[k],
                 q_out, count, lockup_err, e.q[11:0], e.c[11:0], e.e);
      end
    end
  endtask

  task automatic test_gapped_shift();
    exp_t e;
    bit sh;
    for (int i = 0; i < 500; i++) begin
      sh = 1'($urandom_range(0, 1));
      cyc(0, sh, 1'b0, 0);
      e = exp_q.pop_front();
      vectors++;
      if ({q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL gapped[%0d] sh=%b: got q=%h c=%h, want q=%h c=%h", i, sh,
                 q_out, count, e.q[11:0], e.c[11:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 1234; i++) begin
      cyc(0, 1'b1, 1'b0, 0);
      void'(exp_q.pop_front());
    end
    vectors++;
    if (count !== 12'd1234) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %0d, want 1234", count);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({q_out, count, max_tick, lockup_err} !== {12'h367, 12'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got q=%h c=%h t=%b, want q=367 c=000 t=0", q_out, count, max_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b1, 1'b0, 0);
      e = exp_q.pop_front();
      vectors++;
      if ({q_out, count, max_tick, lockup_err} !== {e.q[11:0], e.c[11:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL resume[%0d]: got q=%h c=%h, want q=%h c=%h", i,
                 q_out, count, e.q[11:0], e.c[11:0]);
      end
    end
  endtask

  task automatic test_small();
    exp_t e;
    bit seen[16];
    int nz;
    nz = 0;
    rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 1'b1, 1'b0, 0);
      e = exp_q.pop_front();
      vectors++;
      if ({s_q, s_c, s_t, s_e} !== {e.q[3:0], e.c[3:0], e.t, e.e}) begin
        miscompares++;
        $display("FAIL small[%0d]: got q=%h c=%h t=%b, want q=%h c=%h t=%b", i,
                 s_q, s_c, s_t, e.q[3:0], e.c[3:0], e.t);
      end
      if (s_q != 4'h0 && !seen[s_q]) nz++;
      seen[s_q] = 1'b1;
    end
    vectors++;
    if (nz != 15 || s_q !== 4'h1 || s_t !== 1'b1) begin
      miscompares++;
      $display("FAIL small_period: got %0d distinct nonzero, q=%h t=%b, want 15, q=1 t=1", nz, s_q, s_t);
    end
    cyc(1, 1'b1, 1'b0, 0);
    void'(exp_q.pop_front());
    cyc(1, 1'b0, 1'b1, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if ({s_q, s_c, s_t, s_e} !== {e.q[3:0], e.c[3:0], e.t, e.e} || s_e !== 1'b1) begin
      miscompares++;
      $display("FAIL small_lockload: got q=%h c=%h e=%b, want q=1 c=0 e=1", s_q, s_c, s_e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_full_period();
    test_load();
    test_gapped_shift();
    test_async_reset();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
